uart_rx_prog: RTL and testbench

Runtime-programmable UART receiver: successor to the fixed-format receiver. Character length, parity, stop bits and bit period are set through configuration inputs, not compile-time parameters. Received characters, with per-character error and break status, go into a receive FIFO. The FIFO is drained through a valid/ready stream towards the peripheral register file or DMA.

---
 rtl/uart_rx_prog.sv | 252 +++++++++++++++++++++++++
 tb/tb_uart_rx_prog.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_prog.sv
// uart_rx_prog: runtime-configurable UART receiver with per-character error/break status.
// Define UART_RX_PROG_FIFO_EN for a FIFO_DEPTH-entry receive FIFO; otherwise a single holding register is used.
module uart_rx_prog #(
    parameter int NCHAR_MAX   = 9,
    parameter int DIV_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 uart_rx,
    input  logic [DIV_W-1:0]     cfg_bit_div,
    input  logic [3:0]           cfg_nchar,
    input  logic                 cfg_parity_en,
    input  logic                 cfg_parity_odd,
    input  logic                 cfg_nstop,
    output logic [NCHAR_MAX-1:0] m_data,
    output logic                 m_frame_err,
    output logic                 m_parity_err,
    output logic                 m_break,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 overrun,
    input  logic                 clr_overrun,
    output logic                 busy
);
    localparam int ENTRY_W = NCHAR_MAX + 3;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK_WAIT
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   edge_q, edge_d;
    logic                   rxs, fall, sample, drop;
    logic [DIV_W-1:0]       cnt_q, cnt_d, div_q, div_d;
    logic [3:0]             nchar_q, nchar_d, bit_idx_q, bit_idx_d;
    logic                   par_en_q, par_en_d, par_odd_q, par_odd_d;
    logic                   nstop_q, nstop_d, stop_idx_q, stop_idx_d;
    logic [NCHAR_MAX-1:0]   data_q, data_d;
    logic                   ferr_q, ferr_d, perr_q, perr_d, zero_q, zero_d;
    logic                   push_q, push_d;
    logic [ENTRY_W-1:0]     entry_q, entry_d;
    logic                   busy_q, busy_d, overrun_q, overrun_d;

    assign rxs    = sync_q[SYNC_STAGES-1];
    assign fall   = edge_q & ~rxs;
    assign sample = (cnt_q == '0);

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], uart_rx};
        edge_d = rxs;
    end

    // Receive FSM; zero_q tracks whether every sampled bit so far was 0 (break detection).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        nchar_d    = nchar_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        nstop_d    = nstop_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        data_d     = data_q;
        ferr_d     = ferr_q;
        perr_d     = perr_q;
        zero_d     = zero_q;
        push_d     = 1'b0;
        entry_d    = entry_q;
        if (state_q != S_IDLE && state_q != S_BRK_WAIT) begin
            cnt_d = sample ? div_q : cnt_q - DIV_W'(1);
        end
        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    state_d    = S_START;
                    cnt_d      = cfg_bit_div >> 1;
                    div_d      = cfg_bit_div;
                    nchar_d    = cfg_nchar;
                    par_en_d   = cfg_parity_en;
                    par_odd_d  = cfg_parity_odd;
                    nstop_d    = cfg_nstop;
                    bit_idx_d  = '0;
                    stop_idx_d = 1'b0;
                    data_d     = '0;
                    ferr_d     = 1'b0;
                    perr_d     = 1'b0;
                    zero_d     = 1'b1;
                end
            end
            S_START: begin
                if (sample) state_d = rxs ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (sample) begin
                    data_d[bit_idx_q] = rxs;
                    zero_d = zero_q & ~rxs;
                    if (bit_idx_q == nchar_q - 4'd1) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (sample) begin
                    perr_d  = (^data_q) ^ rxs ^ par_odd_q;
                    zero_d  = zero_q & ~rxs;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (sample) begin
                    ferr_d = ferr_q | ~rxs;
                    zero_d = zero_q & ~rxs;
                    if (stop_idx_q == nstop_q) begin
                        push_d  = 1'b1;
                        entry_d = zero_d ? {1'b1, 1'b0, 1'b1, {NCHAR_MAX{1'b0}}}
                                         : {1'b0, perr_q, ferr_d, data_q};
                        state_d = rxs ? S_IDLE : S_BRK_WAIT;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            S_BRK_WAIT: begin
                if (rxs) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d    = (state_d != S_IDLE);
        overrun_d = drop ? 1'b1 : (clr_overrun ? 1'b0 : overrun_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sync_q     <= '1;
            edge_q     <= 1'b1;
            cnt_q      <= '0;
            div_q      <= '0;
            nchar_q    <= '0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            nstop_q    <= 1'b0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            data_q     <= '0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
            zero_q     <= 1'b0;
            push_q     <= 1'b0;
            entry_q    <= '0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            edge_q     <= edge_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            nchar_q    <= nchar_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            nstop_q    <= nstop_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            data_q     <= data_d;
            ferr_q     <= ferr_d;
            perr_q     <= perr_d;
            zero_q     <= zero_d;
            push_q     <= push_d;
            entry_q    <= entry_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
        end
    end

    assign busy    = busy_q;
    assign overrun = overrun_q;

`ifdef UART_RX_PROG_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0] mem_d [FIFO_DEPTH];
    logic [AW:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic               full, empty, pop;

    // Full when indices match but the wrap bits differ.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign pop   = ~empty & m_ready;
    assign drop  = push_q & full & ~pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_q && !drop) begin
            mem_d[wr_ptr_q[AW-1:0]] = entry_q;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign m_valid = ~empty;
    assign {m_break, m_parity_err, m_frame_err, m_data} = mem_q[rd_ptr_q[AW-1:0]];
`else
    logic               hold_valid_q, hold_valid_d, pop;
    logic [ENTRY_W-1:0] hold_q, hold_d;

    assign pop  = hold_valid_q & m_ready;
    assign drop = push_q & hold_valid_q & ~pop;

    always_comb begin
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q & ~pop;
        if (push_q && !drop) begin
            hold_d       = entry_q;
            hold_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid_q <= 1'b0;
            hold_q       <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_q       <= hold_d;
        end
    end

    assign m_valid = hold_valid_q;
    assign {m_break, m_parity_err, m_frame_err, m_data} = hold_q;
`endif
endmodule

// File: tb/tb_uart_rx_prog.sv
// Directed bench for uart_rx_prog; works for both the FIFO and the holding-register build.
// Entries are compared as {break, parity_err, frame_err, data[8:0]}.
module tb_uart_rx_prog;
`ifdef UART_RX_PROG_FIFO_EN
    localparam int CAP = 8;
`else
    localparam int CAP = 1;
`endif

    logic        clk, rst_n, uart_rx;
    logic [15:0] cfg_bit_div;
    logic [3:0]  cfg_nchar;
    logic        cfg_parity_en, cfg_parity_odd, cfg_nstop;
    logic [8:0]  m_data;
    logic        m_frame_err, m_parity_err, m_break, m_valid, m_ready;
    logic        overrun, clr_overrun, busy;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [11:0] exp_q[$];

    uart_rx_prog #(.NCHAR_MAX(9), .DIV_W(16), .SYNC_STAGES(2), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx),
        .cfg_bit_div(cfg_bit_div), .cfg_nchar(cfg_nchar),
        .cfg_parity_en(cfg_parity_en), .cfg_parity_odd(cfg_parity_odd), .cfg_nstop(cfg_nstop),
        .m_data(m_data), .m_frame_err(m_frame_err), .m_parity_err(m_parity_err),
        .m_break(m_break), .m_valid(m_valid), .m_ready(m_ready),
        .overrun(overrun), .clr_overrun(clr_overrun), .busy(busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // driver tasks; all start and end on a falling clock edge
    task automatic set_cfg(input logic [15:0] div, input logic [3:0] nc,
                           input logic pe, input logic odd, input logic ns);
        cfg_bit_div = div; cfg_nchar = nc; cfg_parity_en = pe;
        cfg_parity_odd = odd; cfg_nstop = ns;
    endtask

    task automatic send_bit(input logic b, input int cyc);
        uart_rx = b;
        repeat (cyc) @(negedge clk);
    endtask

    task automatic send_frame(input logic [8:0] d, input logic flip_par, input logic stop2_low);
        int   nb  = int'(cfg_nchar);
        int   cyc = int'(cfg_bit_div) + 1;
        logic pe  = cfg_parity_en;
        logic p   = cfg_parity_odd;
        logic ns  = cfg_nstop;
        send_bit(1'b0, cyc);
        for (int i = 0; i < nb; i++) begin
            send_bit(d[i], cyc);
            p = p ^ d[i];
        end
        if (pe) send_bit(p ^ flip_par, cyc);
        send_bit(1'b1, cyc);
        if (ns) send_bit(~stop2_low, cyc);
        send_bit(1'b1, 2 * cyc);
    endtask

    // scoreboard: compare head entry against the expected queue, then pop it
    task automatic drain_one(input string tag);
        int          t = 0;
        logic [11:0] exp;
        while (!m_valid && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_valid"}, m_valid, 1);
        exp = exp_q.pop_front();
        if (m_valid) begin
            check(tag, {m_break, m_parity_err, m_frame_err, m_data}, exp);
            m_ready = 1'b1;
            @(negedge clk);
            m_ready = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0; uart_rx = 1'b1; m_ready = 1'b0; clr_overrun = 1'b0;
        set_cfg(16'd15, 4'd8, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_valid", m_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        check("rst_entry", {m_break, m_parity_err, m_frame_err, m_data}, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 8E1 0xA5 with exact push latency: stop sample at edge 171, entry visible after edge 172
        set_cfg(16'd15, 4'd8, 1'b1, 1'b0, 1'b0);
        exp_q.push_back({3'b000, 9'h0A5});
        fork
            send_frame(9'h0A5, 1'b0, 1'b0);
            begin
                repeat (171) @(negedge clk);
                check("lat_before", m_valid, 0);
                @(negedge clk);
                check("lat_after", m_valid, 1);
            end
        join
        drain_one("e8_a5");

        // 7O2 with inverted parity bit
        set_cfg(16'd15, 4'd7, 1'b1, 1'b1, 1'b1);
        exp_q.push_back({3'b010, 9'h041});
        send_frame(9'h041, 1'b1, 1'b0);
        drain_one("o7_perr");

        // 9N2 with second stop bit low
        set_cfg(16'd15, 4'd9, 1'b0, 1'b0, 1'b1);
        exp_q.push_back({3'b001, 9'h1FF});
        send_frame(9'h1FF, 1'b0, 1'b1);
        drain_one("n9_ferr");

        // break: 20 bit times low
        set_cfg(16'd15, 4'd8, 1'b0, 1'b0, 1'b0);
        exp_q.push_back({3'b101, 9'h000});
        send_bit(1'b0, 20 * 16);
        send_bit(1'b1, 64);
        drain_one("break");
        repeat (40) @(negedge clk);
        check("break_single", m_valid, 0);
        exp_q.push_back({3'b000, 9'h055});
        send_frame(9'h055, 1'b0, 1'b0);
        drain_one("after_brk");

        // 3-cycle glitch
        send_bit(1'b0, 3);
        send_bit(1'b1, 2);
        check("glitch_busy", busy, 1);
        repeat (40) @(negedge clk);
        check("glitch_idle", busy, 0);
        check("glitch_noent", m_valid, 0);

        // cfg_nchar changed mid-frame has no effect on the current frame
        fork
            send_frame(9'h0C3, 1'b0, 1'b0);
            begin
                repeat (60) @(negedge clk);
                cfg_nchar = 4'd5;
            end
        join
        cfg_nchar = 4'd8;
        exp_q.push_back({3'b000, 9'h0C3});
        drain_one("cfg_chg");

        // overrun: CAP+1 frames without draining
        for (int i = 0; i <= CAP; i++) begin
            send_frame(9'(i), 1'b0, 1'b0);
            if (i < CAP) exp_q.push_back({3'b000, 9'(i)});
        end
        check("ovr_set", overrun, 1);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        check("ovr_clr", overrun, 0);
        for (int i = 0; i < CAP; i++) drain_one("ovr_drain");
        check("ovr_empty", m_valid, 0);

        // full storage, pop in the push cycle (8N1: stop sample edge 155, push edge 156)
        for (int i = 0; i < CAP; i++) begin
            send_frame(9'h010 + 9'(i), 1'b0, 1'b0);
            exp_q.push_back({3'b000, 9'h010 + 9'(i)});
        end
        fork
            send_frame(9'h010 + 9'(CAP), 1'b0, 1'b0);
            begin
                repeat (155) @(negedge clk);
                check("pp_head", {m_break, m_parity_err, m_frame_err, m_data}, exp_q.pop_front());
                m_ready = 1'b1;
                @(negedge clk);
                m_ready = 1'b0;
            end
        join
        exp_q.push_back({3'b000, 9'h010 + 9'(CAP)});
        check("pp_no_ovr", overrun, 0);
        for (int i = 0; i < CAP; i++) drain_one("pp_drain");
        check("pp_empty", m_valid, 0);

        // reset in the middle of a frame with an entry pending
        send_frame(9'h033, 1'b0, 1'b0);
        send_bit(1'b0, 40);
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        uart_rx = 1'b1;
        @(negedge clk);
        check("mid_valid", m_valid, 0);
        check("mid_busy0", busy, 0);
        check("mid_entry", {m_break, m_parity_err, m_frame_err, m_data}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        exp_q.push_back({3'b000, 9'h05A});
        send_frame(9'h05A, 1'b0, 1'b0);
        drain_one("post_rst");
        check("final_empty", m_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
